// File: rtl/p2s_tx_arbiter_pkg.sv
// Shared types and constants for the p2s transmit arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package p2s_tx_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 4;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // A length field of zero encodes a full 16-bit word.
  function automatic logic [LEN_W:0] eff_bits(input logic [LEN_W-1:0] len);
    return (len == '0) ? (LEN_W+1)'(WORD_W) : {1'b0, len};
  endfunction

endpackage

// File: rtl/p2s_tx_arbiter_rr_arbiter.sv
// Round-robin pick of the first request at or after the pointer, wrapping.
// Latency: grant is combinational; pointer advances on the edge a grant is taken.
// Backpressure: pointer holds while enable is low, so pending requests keep their turn.
module p2s_tx_arbiter_rr_arbiter
  import p2s_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_vld
);

  logic [ID_W-1:0] ptr;

  function automatic int wrap_idx(input int base, input int ofs);
    int s;
    s = base + ofs;
    return (s >= NREQ) ? s - NREQ : s;
  endfunction

  // Scan from the pointer and take the first set request.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && req[wrap_idx(int'(ptr), i)]) begin
        grant_vld                       = 1'b1;
        grant_id                        = ID_W'(wrap_idx(int'(ptr), i));
        grant[wrap_idx(int'(ptr), i)]   = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner whenever a grant is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (enable && grant_vld) begin
      ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/p2s_tx_arbiter.sv
// Shares one parallel-to-serial shifter among NREQ requesters, round-robin.
// Latency: gnt 1 cycle after req seen in IDLE; done 1 cycle after ser_done; GAP_CYCLES idle after.
// Backpressure: requests wait (level-held) while busy; next grant earliest 1 cycle after IDLE entry.
module p2s_tx_arbiter
  import p2s_tx_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [4*NREQ-1:0]    req_len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      err,
  output logic                 busy,
  output logic [2:0]           active_id,
  output logic                 ser_clear,
  output logic                 ser_enable,
  output logic [15:0]          ser_data,
  output logic [3:0]           ser_len,
  input  logic                 ser_done
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t          state;
  logic [CNT_W-1:0] send_cnt;
  logic [3:0]      gap_cnt;
  logic            ser_clear_q;
  logic [NREQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_id;
  logic            arb_vld;
  logic [NREQ-1:0] owner_oh;

  p2s_tx_arbiter_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .enable    (state == ST_IDLE),
    .grant     (arb_grant),
    .grant_id  (arb_id),
    .grant_vld (arb_vld)
  );

  assign owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << active_id;

  // A reset mid-word must also wipe the shifter, so reset feeds the clear strobe directly.
  assign ser_clear = ser_clear_q | reset;

  // Main scheduler: grant, clear, send with timeout, idle gap, completion pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      busy        <= 1'b0;
      ser_clear_q <= 1'b0;
      ser_enable  <= 1'b0;
      ser_data    <= '0;
      ser_len     <= '0;
      active_id   <= '0;
      send_cnt    <= '0;
      gap_cnt     <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_vld) begin
            state       <= ST_CLEAR;
            gnt         <= arb_grant;
            ser_data    <= req_data[WORD_W*arb_id +: WORD_W];
            ser_len     <= req_len[LEN_W*arb_id +: LEN_W];
            active_id   <= arb_id;
            busy        <= 1'b1;
            ser_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state       <= ST_SEND;
          ser_clear_q <= 1'b0;
          ser_enable  <= 1'b1;
          send_cnt    <= '0;
        end
        ST_SEND: begin
          if (ser_done || (send_cnt == CNT_W'(TIMEOUT - 1))) begin
            ser_enable <= 1'b0;
            if (ser_done) begin
              done <= owner_oh;
            end else begin
              err <= owner_oh;
            end
            if (GAP_CYCLES == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end
          end else begin
            send_cnt <= send_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_tx_arbiter.sv
// Directed bench: default instance (GAP_CYCLES=2) plus a GAP_CYCLES=0 instance,
// each driving a behavioural shifter that raises done while emitting the last bit.
module tb_p2s_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  req_z = '0;
  logic [63:0] req_data = '0;
  logic [15:0] req_len = '0;
  logic        stuck = 1'b0;

  logic [3:0]  gnt, done, err, gnt_z, done_z, err_z;
  logic        busy, busy_z;
  logic [2:0]  active_id, aid_z;
  logic [1:0]  s_clr, s_en, s_done;
  logic [15:0] s_dat [2];
  logic [3:0]  s_len [2];

  // behavioural shifter state, one per instance
  logic [4:0]  sh_cnt [2];
  logic [4:0]  sh_l [2];
  logic [1:0]  sh_dn;
  int          en_cnt [2] = '{0, 0};
  int          line_n = 0;
  logic [15:0] line_bits = '0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  p2s_tx_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_len(req_len),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .active_id(active_id),
    .ser_clear(s_clr[0]), .ser_enable(s_en[0]), .ser_data(s_dat[0]), .ser_len(s_len[0]),
    .ser_done(s_done[0])
  );

  p2s_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_z), .req_data(req_data), .req_len(req_len),
    .gnt(gnt_z), .done(done_z), .err(err_z), .busy(busy_z), .active_id(aid_z),
    .ser_clear(s_clr[1]), .ser_enable(s_en[1]), .ser_data(s_dat[1]), .ser_len(s_len[1]),
    .ser_done(s_done[1])
  );

  always_comb begin
    s_done = '0;
    for (int k = 0; k < 2; k++) begin
      sh_l[k]   = (s_len[k] == 4'd0) ? 5'd16 : {1'b0, s_len[k]};
      s_done[k] = !stuck && !s_clr[k] &&
                  (sh_dn[k] || (s_en[k] && sh_cnt[k] == sh_l[k] - 5'd1));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (s_en[k]) en_cnt[k] <= en_cnt[k] + 1;
      if (s_clr[k]) begin
        sh_cnt[k] <= '0;
        sh_dn[k]  <= 1'b0;
      end else if (s_en[k] && !sh_dn[k]) begin
        if (sh_cnt[k] == sh_l[k] - 5'd1) sh_dn[k] <= 1'b1;
        sh_cnt[k] <= sh_cnt[k] + 5'd1;
      end
    end
    if (!s_clr[0] && s_en[0] && !sh_dn[0]) begin
      line_n    <= line_n + 1;
      line_bits <= {line_bits[14:0], s_dat[0][5'd15 - sh_cnt[0]]};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req = '0; req_z = '0; stuck = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; req_z = '0;
    tick; tick;
    total++; if (s_clr[0] !== 1'b1) $display("FAIL reset_clear: got %b want 1", s_clr[0]); else passed++;
    reset = 1'b0;
    tick;
    total++; if ({gnt, done, err} !== 12'h000) $display("FAIL reset_pulses: got %h want 000", {gnt, done, err}); else passed++;
    total++; if ({busy, s_clr[0], s_en[0]} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {busy, s_clr[0], s_en[0]}); else passed++;
    total++; if ({s_dat[0], s_len[0], active_id} !== 23'h0) $display("FAIL reset_regs: got %h want 0", {s_dat[0], s_len[0], active_id}); else passed++;
    total++; if ({gnt_z, done_z, err_z, busy_z, s_clr[1], s_en[1]} !== 15'h0) $display("FAIL reset_dut0: got %h want 0", {gnt_z, done_z, err_z, busy_z, s_clr[1], s_en[1]}); else passed++;
  endtask

  task automatic test_single;
    int n0, e0;
    req_data[15:0] = 16'hA000; req_len[3:0] = 4'd4;
    n0 = line_n; e0 = en_cnt[0];
    req = 4'b0001;
    tick;
    total++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else passed++;
    total++; if ({s_clr[0], s_dat[0], s_len[0]} !== {1'b1, 16'hA000, 4'd4}) $display("FAIL single_latch: got %h want 1a0004", {s_clr[0], s_dat[0], s_len[0]}); else passed++;
    req = 4'b0000;
    tick;
    total++; if ({gnt, s_clr[0], s_en[0]} !== 6'b000001) $display("FAIL single_send: got %b want 000001", {gnt, s_clr[0], s_en[0]}); else passed++;
    repeat (4) tick;
    total++; if ({done, s_en[0], busy} !== 6'b000101) $display("FAIL single_done: got %b want 000101", {done, s_en[0], busy}); else passed++;
    total++; if (en_cnt[0] - e0 !== 4) $display("FAIL single_en_cycles: got %0d want 4", en_cnt[0] - e0); else passed++;
    total++; if (line_n - n0 !== 4 || line_bits[3:0] !== 4'b1010) $display("FAIL single_line: got %0d bits %b want 4 bits 1010", line_n - n0, line_bits[3:0]); else passed++;
    tick;
    total++; if ({busy, done} !== 5'b10000) $display("FAIL single_gap: got %b want 10000", {busy, done}); else passed++;
    tick;
    total++; if (busy !== 1'b0 || s_dat[0] !== 16'hA000) $display("FAIL single_idle: got busy %b data %h want 0 a000", busy, s_dat[0]); else passed++;
  endtask

  task automatic test_round_robin;
    int w;
    logic [3:0] exp_oh;
    do_reset;
    req_data = {4{16'h8000}}; req_len = 16'h1111;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      do begin tick; w++; end while (gnt === 4'b0000 && w < 40);
      exp_oh = 4'b0001 << (g % 4);
      total++; if (gnt !== exp_oh || active_id !== 3'(g % 4)) $display("FAIL rr_order%0d: got %b id %0d want %b", g, gnt, active_id, exp_oh); else passed++;
      if (g > 0) begin
        total++; if (w !== 5) $display("FAIL rr_spacing%0d: got %0d want 5", g, w); else passed++;
      end
    end
    req = 4'b0000;
    w = 0;
    do begin tick; w++; end while (busy !== 1'b0 && w < 40);
  endtask

  task automatic test_len0;
    int n0, e0, w;
    bit len_bad;
    req_data[31:16] = 16'hFFFF; req_len[7:4] = 4'd0;
    n0 = line_n; e0 = en_cnt[0];
    req = 4'b0010;
    tick;
    total++; if (gnt !== 4'b0010 || s_len[0] !== 4'd0) $display("FAIL len0_gnt: got %b len %0d want 0010 0", gnt, s_len[0]); else passed++;
    req = 4'b0000;
    w = 0; len_bad = 0;
    do begin tick; w++; if (s_len[0] !== 4'd0) len_bad = 1; end while (done === 4'b0000 && w < 40);
    total++; if (done !== 4'b0010 || w !== 17) $display("FAIL len0_done: got %b after %0d want 0010 after 17", done, w); else passed++;
    total++; if (en_cnt[0] - e0 !== 16) $display("FAIL len0_en_cycles: got %0d want 16", en_cnt[0] - e0); else passed++;
    total++; if (line_n - n0 !== 16 || line_bits !== 16'hFFFF) $display("FAIL len0_line: got %0d bits %h want 16 ffff", line_n - n0, line_bits); else passed++;
    total++; if (len_bad !== 1'b0) $display("FAIL len0_len_stable: got %b want 0", len_bad); else passed++;
    tick; tick;
    total++; if (busy !== 1'b0) $display("FAIL len0_idle: got %b want 0", busy); else passed++;
  endtask

  task automatic test_timeout;
    bit bad;
    stuck = 1'b1;
    req_data[63:48] = 16'h1234; req_len[15:12] = 4'd8;
    req = 4'b1000;
    tick;
    total++; if (gnt !== 4'b1000) $display("FAIL to_gnt: got %b want 1000", gnt); else passed++;
    req = 4'b0000;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (err !== 4'b0000 || done !== 4'b0000 || s_en[0] !== 1'b1) bad = 1;
    end
    total++; if (bad !== 1'b0) $display("FAIL to_send_window: got %b want 0", bad); else passed++;
    tick;
    total++; if ({err, done, s_en[0]} !== 9'b100000000) $display("FAIL to_err: got %b want 100000000", {err, done, s_en[0]}); else passed++;
    tick; tick;
    total++; if (busy !== 1'b0 || err !== 4'b0000) $display("FAIL to_idle: got busy %b err %b want 0 0000", busy, err); else passed++;
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit bad;
    int w;
    req_data[15:0] = 16'hC300; req_len[3:0] = 4'd8;
    req = 4'b0001;
    tick;
    total++; if (gnt !== 4'b0001) $display("FAIL rmid_gnt: got %b want 0001", gnt); else passed++;
    req = 4'b0000;
    tick; tick; tick;
    reset = 1'b1;
    #1;
    total++; if (s_clr[0] !== 1'b1) $display("FAIL rmid_clear: got %b want 1", s_clr[0]); else passed++;
    tick;
    reset = 1'b0;
    #1;
    total++; if ({gnt, done, err, busy, s_en[0], s_clr[0]} !== 15'h0) $display("FAIL rmid_ctl: got %h want 0", {gnt, done, err, busy, s_en[0], s_clr[0]}); else passed++;
    total++; if ({s_dat[0], s_len[0], active_id} !== 23'h0) $display("FAIL rmid_regs: got %h want 0", {s_dat[0], s_len[0], active_id}); else passed++;
    bad = 0;
    repeat (4) begin tick; if (done !== 4'b0000 || err !== 4'b0000) bad = 1; end
    total++; if (bad !== 1'b0) $display("FAIL rmid_no_pulse: got %b want 0", bad); else passed++;
    req_data[47:32] = 16'h8000; req_len[11:8] = 4'd1;
    req = 4'b0100;
    tick;
    total++; if (gnt !== 4'b0100) $display("FAIL rmid_fresh_gnt: got %b want 0100", gnt); else passed++;
    req = 4'b0000;
    w = 0;
    do begin tick; w++; end while (done === 4'b0000 && w < 40);
    total++; if (done !== 4'b0100) $display("FAIL rmid_fresh_done: got %b want 0100", done); else passed++;
    tick; tick;
  endtask

  task automatic test_drop;
    bit bad, saw_done;
    req_data[15:0] = 16'hF000; req_len[3:0] = 4'd4;
    req = 4'b0001;
    tick;
    total++; if (gnt !== 4'b0001) $display("FAIL drop_gnt0: got %b want 0001", gnt); else passed++;
    bad = 0; saw_done = 0;
    req = 4'b0100;
    tick; if (gnt !== 4'b0000) bad = 1;
    tick; if (gnt !== 4'b0000) bad = 1;
    req = 4'b0000;
    repeat (15) begin
      tick;
      if (gnt !== 4'b0000) bad = 1;
      if (done[0] === 1'b1) saw_done = 1;
    end
    total++; if (bad !== 1'b0) $display("FAIL drop_never_granted: got %b want 0", bad); else passed++;
    total++; if (saw_done !== 1'b1 || busy !== 1'b0) $display("FAIL drop_owner_done: got %b busy %b want 1 0", saw_done, busy); else passed++;
  endtask

  task automatic test_gap0;
    int w;
    req_data[31:0] = {16'h8000, 16'h8000}; req_len[7:0] = 8'h11;
    req_z = 4'b0011;
    tick;
    total++; if (gnt_z !== 4'b0001) $display("FAIL gap0_gnt0: got %b want 0001", gnt_z); else passed++;
    w = 0;
    do begin tick; w++; end while (done_z === 4'b0000 && w < 40);
    total++; if ({done_z, gnt_z, busy_z} !== 9'b000100000) $display("FAIL gap0_done: got %b want 000100000", {done_z, gnt_z, busy_z}); else passed++;
    tick;
    total++; if (gnt_z !== 4'b0010) $display("FAIL gap0_next_gnt: got %b want 0010", gnt_z); else passed++;
    req_z = 4'b0000;
    repeat (4) tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_len0;
    test_timeout;
    test_reset_mid;
    test_drop;
    test_gap0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/p2s_tx_arbiter.md
Name: p2s_tx_arbiter

Overview:
Round-robin scheduler that shares one parallel-to-serial shifter between NREQ requesters. It latches a requester's MSB-aligned word and bit length, then clears the shifter and drives it for the word. It waits for the shifter's done, inserts a configurable idle gap on the line, and reports completion or timeout to the owning requester. It sits between the protocol/command blocks and the single serial output serializer.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_CYCLES, 2, idle cycles inserted after each word (0..15)
TIMEOUT, 20, max SEND cycles before abort (must be > 17)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester request, level, held until gnt
req_data  in  16*NREQ  word i at [16i+15:16i], payload MSB-aligned
req_len  in  4*NREQ  bit count i; 1..15 = that many bits, 0 = 16 bits
gnt  out  NREQ  one-hot one-cycle pulse: word latched
done  out  NREQ  one-hot one-cycle pulse: word fully shifted
err  out  NREQ  one-hot one-cycle pulse: word aborted by timeout
busy  out  1  high in every state except IDLE
active_id  out  3  index of current owner; holds last owner when idle
ser_clear  out  1  reset strobe to shifter
ser_enable  out  1  shift enable to shifter
ser_data  out  16  latched word to shifter
ser_len  out  4  latched length to shifter
ser_done  in  1  shifter done flag, sticky until ser_clear

Behaviour:
- Reset values: gnt, done and err = 0. busy, ser_clear and ser_enable = 0. ser_data, ser_len and active_id = 0. State = IDLE. Round-robin pointer = 0.
- Reset mid-word: the FSM returns to IDLE next edge and ser_enable drops. Reset also asserts ser_clear in that cycle so the shifter is cleared. No done or err pulse is issued.
- IDLE: if any req is set, choose the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's data and len into ser_data and ser_len, and set active_id.
  - Pulse gnt for that requester in the same cycle; go to CLEAR.
  - Pointer becomes winner+1 mod NREQ.
- CLEAR (exactly 1 cycle): ser_clear=1, ser_enable=0; go to SEND.
- SEND: ser_enable=1 and ser_clear=0. A cycle counter counts from 0.
  - If ser_done=1: go to GAP, ser_enable=0 from the next cycle, and pulse done for active_id one cycle after ser_done is seen.
  - Else if the counter reaches TIMEOUT-1: pulse err for active_id and go to GAP.
- Shifter bit count: the shifter raises done while emitting the last bit. Exact bit count on the line = L (or 16 when len=0); the controller keeps enable high until done is sampled.
- GAP: ser_enable=0 for GAP_CYCLES cycles, then go to IDLE. If GAP_CYCLES=0, GAP is skipped and the FSM goes directly to IDLE.
- Next grant timing: earliest next gnt comes the cycle after entering IDLE. There is no back-to-back grant in the done cycle.
- Requests arriving while busy are simply pending; they are never lost as long as req is held.
- A requester that drops req before gnt is never granted.
- ser_data and ser_len are stable from CLEAR through GAP; they change only at a grant.
- gnt, done and err are mutually exclusive per cycle.

Decomposition:
- Shared package: state encoding (IDLE, CLEAR, SEND, GAP), WORD_W=16 and LEN_W=4 constants, and a function to compute the effective bit count from len.
- Sub-module rr_arbiter: NREQ-wide round-robin arbiter. Inputs: req, pointer, enable. Outputs: one-hot grant and binary index. It is combinational plus a pointer register.
- The top level holds the FSM, latches, counters and the pulse generation.

Test Plan:
- Single request, len=4, data=16'hA000 → gnt[0] pulse, one ser_clear cycle, then ser_enable for 4 cycles until the shifter done. Line carries 1,0,1,0; done[0] pulses once; busy low after GAP_CYCLES=2 idle cycles.
- req=4'b1111 held → grant order 0,1,2,3,0. After granting index 3 with pointer wrap, the next grant is 0; no requester is granted twice before the others.
- len=0, data=16'hFFFF → 16 enable cycles; done pulses; ser_len reads 0 throughout.
- Model a stuck shifter (ser_done tied 0) → err[active] pulses after exactly TIMEOUT SEND cycles, no done pulse, FSM back to IDLE after the gap.
- Reset asserted during SEND at bit 3 of 8 → next cycle ser_enable=0, busy=0, all outputs at reset values, no done or err. A fresh request afterwards completes normally.
- req[2] raised and dropped while busy serving req[0] → req[2] never granted. Also, GAP_CYCLES=0 → the next gnt is exactly 1 cycle after IDLE entry.
